// File: rtl/task1_sweep_ctrl.sv
// Self-test sequencer: drives vectors 0..7 onto the Lab-2 datapath, samples x/y after SETTLE_CYCLES,
// and compares them against a golden model; done pulses 8*SETTLE_CYCLES cycles after start, with no backpressure.
module task1_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       x_in,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec,
  output logic [1:0] first_fail_xy,
  output logic       first_fail_valid
);

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [2:0] abc_q, abc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [2:0] ffv_q, ffv_d;
  logic [1:0] ffxy_q, ffxy_d;
  logic       ffvld_q, ffvld_d;

  logic       x_exp, y_exp, mism;
  logic [3:0] err_inc;

  // Golden model; y reduces to a&b.
  assign x_exp   = (vec_q[2] | vec_q[1]) ^ ~vec_q[0];
  assign y_exp   = vec_q[2] & vec_q[1];
  assign mism    = (x_in != x_exp) || (y_in != y_exp);
  assign err_inc = err_q + {3'b000, mism};

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    abc_d   = abc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffxy_d  = ffxy_q;
    ffvld_d = ffvld_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = 3'd0;
          abc_d   = 3'd0;
          busy_d  = 1'b1;
          cnt_d   = RELOAD;
          err_d   = 4'd0;
          pass_d  = 1'b0;
          ffv_d   = 3'd0;
          ffxy_d  = 2'd0;
          ffvld_d = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          abc_d   = 3'd0;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          err_d = err_inc;
          if (mism && !ffvld_q) begin
            ffv_d   = vec_q;
            ffxy_d  = {x_in, y_in};
            ffvld_d = 1'b1;
          end
          if (vec_q != 3'd7) begin
            vec_d = vec_q + 3'd1;
            abc_d = vec_q + 3'd1;
            cnt_d = RELOAD;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc == 4'd0);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        abc_d   = 3'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      abc_q   <= 3'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      ffv_q   <= 3'd0;
      ffxy_q  <= 2'd0;
      ffvld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      abc_q   <= abc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffxy_q  <= ffxy_d;
      ffvld_q <= ffvld_d;
    end
  end

  assign {a_out, b_out, c_out} = abc_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_xy    = ffxy_q;
  assign first_fail_valid = ffvld_q;

endmodule

// File: tb/tb_task1_sweep_ctrl.sv
// Directed bench: two sequencers (settle 2 and settle 1), each driving a datapath stand-in with selectable faults.
module tb_task1_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start2, abort2, start1, abort1;
  logic x2, y2, a2, b2, c2, busy2, done2, pass2, fvld2;
  logic x1, y1, a1, b1, c1, busy1, done1, pass1, fvld1;
  logic [3:0] err2, err1;
  logic [2:0] fv2, fv1;
  logic [1:0] fxy2, fxy1;
  logic xd2, xd1;
  int mode2, mode1;  // 0 good, 1 x stuck 0, 2 y stuck 1, 3 x delayed one cycle
  int checks = 0;
  int failures = 0;

  task1_sweep_ctrl #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .x_in(x2), .y_in(y2),
    .a_out(a2), .b_out(b2), .c_out(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_vec(fv2), .first_fail_xy(fxy2), .first_fail_valid(fvld2));

  task1_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .x_in(x1), .y_in(y1),
    .a_out(a1), .b_out(b1), .c_out(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(fv1), .first_fail_xy(fxy1), .first_fail_valid(fvld1));

  function automatic logic dpx(input logic [2:0] v);
    return (v[2] | v[1]) ^ ~v[0];
  endfunction
  function automatic logic dpy(input logic [2:0] v);
    return v[2] & v[1];
  endfunction

  always @(posedge clk) begin
    xd2 <= dpx({a2, b2, c2});
    xd1 <= dpx({a1, b1, c1});
  end

  always_comb begin
    x2 = dpx({a2, b2, c2});
    y2 = dpy({a2, b2, c2});
    if (mode2 == 1) x2 = 1'b0;
    if (mode2 == 2) y2 = 1'b1;
    if (mode2 == 3) x2 = xd2;
    x1 = dpx({a1, b1, c1});
    y1 = dpy({a1, b1, c1});
    if (mode1 == 3) x1 = xd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full sweep on the settle-2 instance; inj pulses start mid-run to show it is ignored.
  task automatic sweep2(input logic [3:0] e_err, input logic e_pass, input logic [2:0] e_fv,
                        input logic [1:0] e_fxy, input logic e_fvld, input logic inj);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    chk("s2_cleared", {pass2, err2, fvld2}, 32'h0);
    for (int n = 0; n < 16; n++) begin
      chk("s2_seq", {busy2, done2, a2, b2, c2}, {2'b10, 3'(n >> 1)});
      start2 = inj && (n == 5);
      @(negedge clk);
    end
    start2 = 1'b0;
    chk("s2_done", {busy2, done2, a2, b2, c2}, 32'b01111);
    chk("s2_result", {pass2, err2, fv2, fxy2, fvld2}, {e_pass, e_err, e_fv, e_fxy, e_fvld});
    @(negedge clk);
    chk("s2_idle", {busy2, done2, a2, b2, c2}, 32'h0);
    chk("s2_hold", {pass2, err2, fv2, fxy2, fvld2}, {e_pass, e_err, e_fv, e_fxy, e_fvld});
  endtask

  task automatic sweep1(input logic [3:0] e_err, input logic e_pass, input logic [2:0] e_fv,
                        input logic [1:0] e_fxy, input logic e_fvld);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      chk("s1_seq", {busy1, done1, a1, b1, c1}, {2'b10, 3'(n)});
      @(negedge clk);
    end
    chk("s1_done", {busy1, done1, a1, b1, c1}, 32'b01111);
    chk("s1_result", {pass1, err1, fv1, fxy1, fvld1}, {e_pass, e_err, e_fv, e_fxy, e_fvld});
    @(negedge clk);
    chk("s1_idle", {busy1, done1, a1, b1, c1}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; start2 = 1'b0; abort2 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    mode2 = 0; mode1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_dut2", {a2, b2, c2, busy2, done2, pass2, err2, fv2, fxy2, fvld2}, 32'h0);
    chk("rst_dut1", {a1, b1, c1, busy1, done1, pass1, err1, fv1, fxy1, fvld1}, 32'h0);
    rst = 1'b0;

    sweep2(4'd0, 1'b1, 3'd0, 2'b00, 1'b0, 1'b1);
    mode2 = 1;
    sweep2(4'd4, 1'b0, 3'd0, 2'b00, 1'b1, 1'b0);
    mode2 = 2;
    sweep2(4'd6, 1'b0, 3'd0, 2'b11, 1'b1, 1'b0);

    // Abort while vec=3 is on the datapath, x stuck at 0: only vec0 has failed so far.
    mode2 = 1;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (6) @(negedge clk);
    chk("ab_vec3", {busy2, a2, b2, c2}, 32'b1011);
    abort2 = 1'b1;
    @(negedge clk); abort2 = 1'b0;
    chk("ab_stop", {busy2, done2, a2, b2, c2}, 32'h0);
    chk("ab_partial", {pass2, err2, fv2, fxy2, fvld2}, {1'b0, 4'd1, 3'd0, 2'b00, 1'b1});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ab_no_done", {busy2, done2}, 32'h0);
    end
    mode2 = 0;
    sweep2(4'd0, 1'b1, 3'd0, 2'b00, 1'b0, 1'b0);

    // Reset while vec=5 is held, after a passing sweep left pass=1.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (10) @(negedge clk);
    chk("rs_vec5", {busy2, a2, b2, c2}, 32'b1101);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_clear", {a2, b2, c2, busy2, done2, pass2, err2, fv2, fxy2, fvld2}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rs_idle", {busy2, done2, a2, b2, c2}, 32'h0);

    mode2 = 3;
    sweep2(4'd0, 1'b1, 3'd0, 2'b00, 1'b0, 1'b0);

    mode1 = 0;
    sweep1(4'd0, 1'b1, 3'd0, 2'b00, 1'b0);
    mode1 = 3;
    sweep1(4'd6, 1'b0, 3'd1, 2'b10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/task1_sweep_ctrl.md
Name: task1_sweep_ctrl

Overview:
Self-test sequencer for the Lab-2 three-input combinational datapath, with inputs a, b, c and outputs x, y. On a start pulse it drives all 8 input vectors onto the datapath in ascending order. After a programmable settle time it samples x and y for each vector and compares them against an internal golden model. It then reports pass/fail, the mismatch count and the first failing vector. It sits between the board-level start button/LEDs and the datapath instance.

Parameters:
SETTLE_CYCLES, 2, clock cycles each vector is held before x/y are sampled; legal range 1..255.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin sweep; sampled only in IDLE.
abort  input  1  cancel a running sweep.
x_in  input  1  datapath output x.
y_in  input  1  datapath output y.
a_out  output  1  datapath input a; vec[2].
b_out  output  1  datapath input b; vec[1].
c_out  output  1  datapath input c; vec[0].
busy  output  1  high while the sweep is running.
done  output  1  one-cycle pulse when the sweep completes.
pass  output  1  high when the last completed sweep had zero mismatches.
err_count  output  4  number of mismatching vectors, 0..8.
first_fail_vec  output  3  {a,b,c} of the first mismatching vector.
first_fail_xy  output  2  observed {x,y} at the first mismatch.
first_fail_valid  output  1  high when the first_fail fields are valid.

Behaviour:
- Golden model, with {a,b,c} = vec:
  - x_exp = (a|b) ^ ~c, giving vec0..7 -> 1,0,0,1,0,1,0,1.
  - y_exp = (a|b) & (~(a&b) ^ (a|b)), which equals a&b, giving vec0..7 -> 0,0,0,0,0,0,1,1.
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset value of every output is 0. On reset: state=IDLE, vec=0, settle counter=0.
- Reset takes priority over start and abort, and applies mid-sweep as well.
- IDLE, start=1 at an edge:
  - Go to RUN.
  - vec <= 0 and {a_out,b_out,c_out} <= 000.
  - busy <= 1.
  - Load settle counter with SETTLE_CYCLES-1.
  - Clear err_count, pass and first_fail_* (all three fields and first_fail_valid).
- RUN:
  - At each edge where the counter is non-zero, decrement it.
  - At the edge where the counter is 0, sample x_in/y_in and compare them with the golden model for the current vec.
  - Each vector is therefore held for exactly SETTLE_CYCLES cycles. It is sampled at the SETTLE_CYCLES-th edge after it appears.
- On mismatch (x or y differs):
  - err_count increments by 1 per vector, not per bit.
  - If first_fail_valid=0, capture vec and {x_in,y_in} and set first_fail_valid.
- After a sample with vec<7:
  - vec increments.
  - Outputs take the new vector on the same edge.
  - Counter reloads to SETTLE_CYCLES-1.
- After the sample at vec=7:
  - Go to DONE.
  - busy <= 0, done <= 1.
  - pass <= 1 if the final err_count is 0 (including the vec=7 result).
  - {a,b,c} hold 111.
- DONE lasts one cycle. Then: done <= 0, go to IDLE, {a,b,c} <= 000.
- Results (pass, err_count, first_fail_*) hold until the next accepted start or reset.
- Latency from the start edge to the done-high cycle: 8*SETTLE_CYCLES cycles.
- start while in RUN or DONE is ignored.
- abort=1 in RUN at an edge:
  - Go to IDLE.
  - busy <= 0, {a,b,c} <= 000.
  - No done pulse; pass stays 0.
  - err_count and first_fail_* keep their partial values. The sample scheduled on that edge is discarded.
- abort in IDLE/DONE has no effect. Simultaneous start+abort in IDLE: start wins.
- err_count saturates naturally at 8 (at most 8 samples); no wraparound is possible.

Test Plan:
- Correct datapath connected, SETTLE_CYCLES=2, start pulse -> vec 0..7 each held 2 cycles; done high 16 cycles after the start edge; pass=1, err_count=0, first_fail_valid=0.
- x_in stuck at 0 -> mismatches at vec 0,3,5,7; err_count=4, first_fail_vec=000, first_fail_xy=00, pass=0.
- y_in stuck at 1 -> mismatches at vec 0..5; err_count=6, first_fail_vec=000, first_fail_xy=11 (x correct=1).
- abort asserted at vec=3 -> busy falls next edge, abc=000, no done, err_count reflects vec 0..2 only; a following start with the correct datapath -> pass=1, err_count=0.
- rst asserted mid-sweep (vec=5) -> next cycle all outputs 0, state IDLE; start during RUN ignored (vec sequence unbroken).
- SETTLE_CYCLES=1 -> new vector every cycle, done 8 cycles after start; x_in with a 1-cycle pipeline delay produces mismatches, while with SETTLE_CYCLES=2 the same delayed datapath gives pass=1.
